display_scanout: RTL
====================

Name: display_scanout

Overview:
- Pixel-clock scan-out engine that generates VGA 640x480@60 timing from a 320x240, 8 bpp framebuffer.
- Sits directly downstream of graphics memory: it drives the memory controller's GPU read port (GPUAddress) and consumes GPUData.
- Each framebuffer byte is RGB332 and is pixel-doubled 2x2 onto the screen.
- Also emits a once-per-frame pulse for software frame pacing.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- FB_WIDTH, 320, framebuffer bytes per row
- SCALE_SHIFT, 1, log2 of the pixel/line replication factor
- FB_BASE, 32'h0, byte address of framebuffer pixel (0,0) in the graphics-memory space

Ports:
- Clock  in  1  pixel clock; same clock as the memory controller's GPUClock
- Reset  in  1  synchronous, active-high
- GPUAddress  out  32  byte address presented to the graphics memory read port
- GPUData  in  8  pixel byte returned one clock after GPUAddress is sampled
- Red  out  4  red output
- Green  out  4  green output
- Blue  out  4  blue output
- HSync  out  1  horizontal sync, active-low
- VSync  out  1  vertical sync, active-low
- Blank  out  1  high outside the visible area, aligned with colour outputs
- FrameStart  out  1  one-clock pulse marking the first visible pixel of each frame, aligned with colour outputs

Behaviour:
- Reset, Reset, synchronous, active-high; clock Clock. While Reset is high at a posedge:
  - HCount, VCount and RowBase clear to 0.
  - Both pipeline stages clear: Red/Green/Blue = 0, HSync = 1, VSync = 1, Blank = 1, FrameStart = 0.
  - Reset mid-frame restarts at (0,0) on the next clock. No partial-line recovery is attempted.
- Counters (S0):
  - HCount runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H_* parameters (800).
  - VCount increments when HCount wraps; range 0..V_TOTAL-1 (525).
  - Both counters wrap to 0 simultaneously at (799, 524).
- S0 decode:
  - active0 = HCount < H_ACTIVE and VCount < V_ACTIVE.
  - hs0 = 0 when H_ACTIVE+H_FRONT <= HCount < H_ACTIVE+H_FRONT+H_SYNC (656..751), else 1.
  - vs0 = 0 when V_ACTIVE+V_FRONT <= VCount < V_ACTIVE+V_FRONT+V_SYNC (490..491), else 1.
  - fs0 = 1 only at HCount=0, VCount=0.
- Address generation (combinational from S0 state, no multiplier):
  - When active0: GPUAddress = FB_BASE + RowBase + (HCount >> SCALE_SHIFT).
  - Otherwise GPUAddress = FB_BASE.
- RowBase update, on each HCount wrap:
  - If VCount = V_TOTAL-1, RowBase <= 0.
  - Else if the low SCALE_SHIFT bits of VCount are all ones and VCount < V_ACTIVE, RowBase <= RowBase + FB_WIDTH.
  - Else hold.
  - Result for defaults: screen lines 0,1 read row 0 (base 0); lines 2,3 read base 320; lines 478,479 read base 76480.
- Pipeline:
  - S1 registers active0/hs0/vs0/fs0. GPUData is valid during S1.
  - At the next posedge, S2 registers the outputs:
    - If active1: Red = {GPUData[7:5], GPUData[7]}, Green = {GPUData[4:2], GPUData[4]}, Blue = {GPUData[1:0], GPUData[1:0]}.
    - Else all colours = 0.
    - HSync = hs1, VSync = vs1, Blank = ~active1, FrameStart = fs1.
  - Total latency from counter state to pins = 2 clocks. Colours and syncs stay mutually aligned, so every output has identical delay.
- Arithmetic:
  - All address arithmetic is 32-bit unsigned; no overflow for legal parameters.
  - GPUAddress[1:0] carries the byte lane; the memory controller registers it alongside the read.

Test Plan:
- Reset held 3 clocks, then released -> during reset HSync=1, VSync=1, Blank=1, colours 0, FrameStart=0; first GPUAddress after release = FB_BASE.
- Free-run one line -> HSync low for exactly 96 clocks, falling 658 clocks after the HCount=0 cycle (656 + 2 latency); line period exactly 800 clocks.
- Free-run one frame -> VSync low for exactly 2 lines (1600 clocks); frame period 420000 clocks; FrameStart pulses exactly once per frame, one clock wide.
- Address sequence on line 0 -> 0,0,1,1,...,319,319; line 1 repeats the same; line 2 starts at 320; line 479 ends at 76799; blanking drives FB_BASE.
- Memory model returning byte 8'b101_011_10 one clock after address -> Red=4'b1011, Green=4'b0110, Blue=4'b1010, with Blank=0 on the same cycle; the first visible pixel appears exactly 2 clocks after (0,0).
- Reset asserted at HCount=300, VCount=200 -> next clock counters at 0 and RowBase 0; two clocks later outputs are in their reset/blank values; the following frame is identical to a cold-start frame.

Source files
------------

// File: rtl/display_scanout.sv
// display_scanout
//   Generates VGA 640x480@60 timing on the pixel clock and scans a 320x240
//   RGB332 framebuffer out of graphics memory, doubling every byte 2x2 onto
//   the screen. Also emits a once-per-frame pulse for software frame pacing.
//
//   Pipeline: S0 = raster counters plus combinational read address,
//             S1 = memory read in flight (GPUData valid), S2 = output pins.
//   Every output has the same two-clock delay from the counter state.
//
// Ports
//   Clock       in   1  pixel clock (shared with the memory controller)
//   Reset       in   1  synchronous, active-high
//   GPUAddress  out 32  byte address to the graphics-memory read port
//   GPUData     in   8  pixel byte, valid one clock after GPUAddress
//   Red/Green/Blue out 4 each  colour outputs
//   HSync, VSync out 1  active-low syncs
//   Blank       out  1  high outside the visible area
//   FrameStart  out  1  one-clock pulse on the first visible pixel of a frame
module display_scanout #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned FB_WIDTH    = 320,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter logic [31:0] FB_BASE     = 32'h0
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] GPUAddress,
    input  logic [7:0]  GPUData,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        HSync,
    output logic        VSync,
    output logic        Blank,
    output logic        FrameStart
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    // Low SCALE_SHIFT bits of VCount; all ones marks the last repeat of a row.
    localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);

    logic [HW-1:0] r_hcount;
    logic [VW-1:0] r_vcount;
    logic [31:0]   r_rowbase;

    logic w_hwrap;
    logic w_active0;
    logic w_hs0;
    logic w_vs0;
    logic w_fs0;

    logic r_active1;
    logic r_hs1;
    logic r_vs1;
    logic r_fs1;

    // ---------------- S0: raster counters and framebuffer row base ----------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_rowbase <= '0;
        end else if (w_hwrap) begin
            r_hcount <= '0;
            if (r_vcount == V_LAST) begin
                r_vcount  <= '0;
                r_rowbase <= '0;
            end else begin
                r_vcount <= r_vcount + 1'b1;
                // Advance one framebuffer row after its last replicated line.
                if (((r_vcount & V_MASK) == V_MASK) && (r_vcount < V_ACT)) begin
                    r_rowbase <= r_rowbase + 32'(FB_WIDTH);
                end
            end
        end else begin
            r_hcount <= r_hcount + 1'b1;
        end
    end

    always_comb begin
        w_hwrap   = (r_hcount == H_LAST);
        w_active0 = (r_hcount < H_ACT) && (r_vcount < V_ACT);
        w_hs0     = !((r_hcount >= H_SS) && (r_hcount < H_SE));
        w_vs0     = !((r_vcount >= V_SS) && (r_vcount < V_SE));
        w_fs0     = (r_hcount == '0) && (r_vcount == '0);
        GPUAddress = FB_BASE;
        if (w_active0) begin
            GPUAddress = FB_BASE + r_rowbase + 32'(r_hcount >> SCALE_SHIFT);
        end
    end

    // ---------------- S1: timing flags wait for the memory read -------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_active1 <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_fs1     <= 1'b0;
        end else begin
            r_active1 <= w_active0;
            r_hs1     <= w_hs0;
            r_vs1     <= w_vs0;
            r_fs1     <= w_fs0;
        end
    end

    // ---------------- S2: output registers ----------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Red        <= '0;
            Green      <= '0;
            Blue       <= '0;
            HSync      <= 1'b1;
            VSync      <= 1'b1;
            Blank      <= 1'b1;
            FrameStart <= 1'b0;
        end else begin
            if (r_active1) begin
                // RGB332 widened to 4 bits by repeating the top bits.
                Red   <= {GPUData[7:5], GPUData[7]};
                Green <= {GPUData[4:2], GPUData[4]};
                Blue  <= {GPUData[1:0], GPUData[1:0]};
            end else begin
                Red   <= '0;
                Green <= '0;
                Blue  <= '0;
            end
            HSync      <= r_hs1;
            VSync      <= r_vs1;
            Blank      <= ~r_active1;
            FrameStart <= r_fs1;
        end
    end

endmodule
